// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter onto one AXI-Stream output.
// The grant is held for a whole packet. The source index is driven on m_tid.
// A packet that runs past MAX_BEATS is cut with a forced tlast, and the rest
// of it is drained from the source without being forwarded.
module axis_pkt_rr_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_BYTES = 8,
  parameter int MAX_BEATS  = 188,
  localparam int IDX_W     = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               sreset,
  input  logic                               enable,
  input  logic [NUM_INPUTS-1:0]              port_mask,
  input  logic [NUM_INPUTS*DATA_BYTES*8-1:0] s_tdata,
  input  logic [NUM_INPUTS*DATA_BYTES-1:0]   s_tkeep,
  input  logic [NUM_INPUTS-1:0]              s_tlast,
  input  logic [NUM_INPUTS-1:0]              s_tvalid,
  output logic [NUM_INPUTS-1:0]              s_tready,
  output logic [DATA_BYTES*8-1:0]            m_tdata,
  output logic [DATA_BYTES-1:0]              m_tkeep,
  output logic                               m_tlast,
  output logic [IDX_W-1:0]                   m_tid,
  output logic                               m_tvalid,
  input  logic                               m_tready,
  output logic                               trunc_pulse,
  output logic [IDX_W-1:0]                   trunc_port,
  output logic [NUM_INPUTS*32-1:0]           pkt_count
);

  localparam int DATA_W = DATA_BYTES * 8;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

  state_t                  state, state_n;
  logic [IDX_W-1:0]        grant, grant_n;
  logic [IDX_W-1:0]        last_grant, last_grant_n;
  logic [15:0]             beat_cnt, beat_cnt_n;
  logic [31:0]             cnt [NUM_INPUTS];

  logic [NUM_INPUTS-1:0]   grant_oh;
  logic                    sel_valid, sel_last;
  logic [DATA_W-1:0]       sel_data;
  logic [DATA_BYTES-1:0]   sel_keep;

  logic [NUM_INPUTS-1:0]   cand;
  logic [2*NUM_INPUTS-1:0] cand_rot;
  logic                    rr_found;
  logic [IDX_W-1:0]        rr_pick;

  logic                    at_limit;
  logic                    pkt_done;

  assign at_limit = (beat_cnt == 16'(MAX_BEATS - 1));

  // Select the granted input's stream signals and build a one-hot of the grant.
  always_comb begin
    grant_oh  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (IDX_W'(i) == grant) begin
        grant_oh[i] = 1'b1;
        sel_valid   = s_tvalid[i];
        sel_last    = s_tlast[i];
        sel_data    = s_tdata[i*DATA_W +: DATA_W];
        sel_keep    = s_tkeep[i*DATA_BYTES +: DATA_BYTES];
      end
    end
  end

  // Round-robin search: rotate a doubled candidate vector so bit 0 is the
  // input just after last_grant, then take the lowest set bit.
  always_comb begin
    cand     = (state == IDLE && enable) ? (s_tvalid & port_mask) : '0;
    cand_rot = {cand, cand} >> (32'(last_grant) + 32'd1);
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned j = 0; j < NUM_INPUTS; j++) begin
      if (!rr_found && cand_rot[j]) begin
        rr_found = 1'b1;
        rr_pick  = IDX_W'((32'(last_grant) + 32'd1 + j) % 32'(NUM_INPUTS));
      end
    end
  end

  // Next-state logic and the combinational output mux.
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    beat_cnt_n   = beat_cnt;
    s_tready     = '0;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tid        = '0;
    trunc_pulse  = 1'b0;
    pkt_done     = 1'b0;
    case (state)
      IDLE: begin
        if (rr_found) begin
          grant_n      = rr_pick;
          last_grant_n = rr_pick;
          beat_cnt_n   = '0;
          state_n      = PASS;
        end
      end
      PASS: begin
        m_tvalid = sel_valid;
        m_tdata  = sel_data;
        m_tkeep  = sel_keep;
        m_tid    = grant;
        // Forced tlast depends only on the beat count, so it stays stable
        // while the beat waits for m_tready.
        m_tlast  = sel_last | at_limit;
        s_tready = grant_oh & {NUM_INPUTS{m_tready}};
        if (sel_valid && m_tready) begin
          beat_cnt_n = beat_cnt + 16'd1;
          if (sel_last) begin
            pkt_done = 1'b1;
            state_n  = IDLE;
          end else if (at_limit) begin
            pkt_done    = 1'b1;
            trunc_pulse = 1'b1;
            state_n     = DROP;
          end
        end
      end
      DROP: begin
        s_tready = grant_oh;
        if (sel_valid && sel_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, arbitration history, truncation record and packet counters.
  always_ff @(posedge clk) begin
    if (sreset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_INPUTS - 1);
      beat_cnt   <= '0;
      trunc_port <= '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) cnt[i] <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      beat_cnt   <= beat_cnt_n;
      if (trunc_pulse) trunc_port <= grant;
      if (pkt_done) begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++)
          if (grant_oh[i]) cnt[i] <= cnt[i] + 32'd1;
      end
    end
  end

  // Flatten the per-input counters onto the output bus.
  always_comb begin
    pkt_count = '0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) pkt_count[i*32 +: 32] = cnt[i];
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Self-checking bench for axis_pkt_rr_arbiter: queue-driven AXIS sources,
// a behavioural arbitration model checked every cycle, a per-packet
// scoreboard, and literal expectations for each directed scenario.
module tb_axis_pkt_rr_arbiter;
  localparam int N    = 4;
  localparam int DB   = 8;
  localparam int DW   = DB * 8;
  localparam int MAXB = 188;
  localparam int IW   = 2;

  typedef struct {
    logic [DW-1:0] d;
    logic [DB-1:0] k;
    logic          l;
  } beat_t;

  logic            clk = 1'b0;
  logic            sreset, enable, m_tready;
  logic [N-1:0]    port_mask, s_tlast, s_tvalid, s_tready;
  logic [N*DW-1:0] s_tdata;
  logic [N*DB-1:0] s_tkeep;
  logic [DW-1:0]   m_tdata;
  logic [DB-1:0]   m_tkeep;
  logic            m_tlast, m_tvalid, trunc_pulse;
  logic [IW-1:0]   m_tid, trunc_port;
  logic [N*32-1:0] pkt_count;

  always #5 clk = ~clk;

  axis_pkt_rr_arbiter #(.NUM_INPUTS(N), .DATA_BYTES(DB), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .sreset(sreset), .enable(enable), .port_mask(port_mask),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tid(m_tid), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .trunc_pulse(trunc_pulse), .trunc_port(trunc_port), .pkt_count(pkt_count)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // sources
  beat_t srcq [N][$];
  bit    popped [N];
  int    gap_pct  = 0;
  bit    rdy_rand = 0;
  // scoreboard
  int exp_len [N][$];
  int exp_seq [N][$];
  int seq_cnt [N];
  // behavioural model: current owner (-1 none), draining flag, beats sent
  int          mo = -1, mlast = N - 1, mbeats = 0, mtp = 0;
  bit          mdrop = 0;
  int unsigned mcnt [N];
  // collector and logs
  int col_beats = 0, col_tid = 0;
  int tid_log[$], len_log[$], hs_log[$];
  int trunc_seen = 0, valid_cycles = 0;
  bit ready02 = 0;
  logic [N-1:0] smp_ready;
  logic         smp_valid;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(int p, int seq, int b);
    return {8'(p), 24'(seq), 32'(b)};
  endfunction

  task automatic add_pkt(int p, int len);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.d = mk(p, seq_cnt[p], b);
      bt.l = (b == len - 1);
      bt.k = bt.l ? 8'($urandom_range(1, 255)) : 8'hFF;
      srcq[p].push_back(bt);
    end
    exp_len[p].push_back(len < MAXB ? len : MAXB);
    exp_seq[p].push_back(seq_cnt[p]);
    seq_cnt[p]++;
  endtask

  task automatic flush_sb();
    for (int p = 0; p < N; p++) begin
      exp_len[p].delete();
      exp_seq[p].delete();
    end
    col_beats = 0;
  endtask

  task automatic flush_src();
    for (int p = 0; p < N; p++) begin
      srcq[p].delete();
      popped[p] = 0;
    end
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    s_tkeep  = '0;
  endtask

  task automatic drive_sources();
    for (int p = 0; p < N; p++) begin
      if (popped[p] || !s_tvalid[p]) begin
        popped[p] = 0;
        if (srcq[p].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
          s_tvalid[p]            = 1'b1;
          s_tdata[p*DW +: DW]    = srcq[p][0].d;
          s_tkeep[p*DB +: DB]    = srcq[p][0].k;
          s_tlast[p]             = srcq[p][0].l;
        end else begin
          s_tvalid[p]            = 1'b0;
          s_tlast[p]             = 1'b0;
          s_tdata[p*DW +: DW]    = '0;
          s_tkeep[p*DB +: DB]    = '0;
        end
      end
    end
    if (rdy_rand) m_tready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic check_outputs();
    logic [N-1:0] er;
    logic ev, etp;
    er  = '0;
    ev  = 1'b0;
    etp = 1'b0;
    if (mo >= 0 && !mdrop) begin
      ev     = s_tvalid[mo];
      er[mo] = m_tready;
      etp    = ev && m_tready && !s_tlast[mo] && (mbeats == MAXB - 1);
    end else if (mo >= 0) begin
      er[mo] = 1'b1;
    end
    check("s_tready", 64'(s_tready), 64'(er));
    check("m_tvalid", 64'(m_tvalid), 64'(ev));
    check("trunc_pulse", 64'(trunc_pulse), 64'(etp));
    check("trunc_port", 64'(trunc_port), 64'(mtp));
    for (int p = 0; p < N; p++) check("pkt_count", 64'(pkt_count[p*32 +: 32]), 64'(mcnt[p]));
    if (ev) begin
      check("m_tdata", m_tdata, s_tdata[mo*DW +: DW]);
      check("m_tkeep", 64'(m_tkeep), 64'(s_tkeep[mo*DB +: DB]));
      check("m_tid", 64'(m_tid), 64'(mo));
      if (m_tready) check("m_tlast", 64'(m_tlast), 64'(s_tlast[mo] || (mbeats == MAXB - 1)));
    end else if (mo < 0) begin
      check("idle_tdata", m_tdata, 64'd0);
      check("idle_side", 64'({m_tkeep, m_tlast, m_tid}), 64'd0);
    end
    smp_ready = s_tready;
    smp_valid = m_tvalid;
    if (m_tvalid) valid_cycles++;
    if (trunc_pulse) trunc_seen++;
    if (s_tready[0] || s_tready[2]) ready02 = 1;
    if (m_tvalid && m_tready) begin
      hs_log.push_back(cyc);
      if (col_beats == 0) col_tid = int'(m_tid);
      else check("pkt_unsplit_tid", 64'(m_tid), 64'(col_tid));
      if (exp_seq[col_tid].size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pkt_expected: beat on id %0d, want no output (no packet pending)", col_tid);
      end else begin
        check("pkt_data", m_tdata, mk(col_tid, exp_seq[col_tid][0], col_beats));
      end
      col_beats++;
      if (m_tlast) begin
        if (exp_len[col_tid].size() > 0) begin
          check("pkt_len", 64'(col_beats), 64'(exp_len[col_tid][0]));
          void'(exp_len[col_tid].pop_front());
          void'(exp_seq[col_tid].pop_front());
        end
        tid_log.push_back(col_tid);
        len_log.push_back(col_beats);
        col_beats = 0;
      end
    end
  endtask

  task automatic update_model();
    for (int p = 0; p < N; p++)
      if (s_tvalid[p] && s_tready[p] && srcq[p].size() > 0) begin
        void'(srcq[p].pop_front());
        popped[p] = 1;
      end
    if (sreset) begin
      mo = -1; mlast = N - 1; mbeats = 0; mdrop = 0; mtp = 0;
      for (int p = 0; p < N; p++) mcnt[p] = 0;
    end else if (mo < 0) begin
      if (enable)
        for (int k = 1; k <= N; k++) begin
          int p = (mlast + k) % N;
          if (s_tvalid[p] && port_mask[p]) begin
            mo = p; mlast = p; mbeats = 0; mdrop = 0;
            break;
          end
        end
    end else if (!mdrop) begin
      if (s_tvalid[mo] && m_tready) begin
        if (s_tlast[mo]) begin
          mcnt[mo]++;
          mo = -1;
        end else if (mbeats == MAXB - 1) begin
          mcnt[mo]++;
          mtp   = mo;
          mdrop = 1;
        end
        mbeats++;
      end
    end else if (s_tvalid[mo] && s_tlast[mo]) begin
      mo = -1;
    end
  endtask

  task automatic cycle();
    drive_sources();
    #3;
    check_outputs();
    update_model();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (srcq[p].size() > 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(int budget, string name);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
      done = all_empty() && (mo < 0);
    end
    check({"drain_", name}, 64'(done), 64'd1);
  endtask

  task automatic do_reset();
    flush_src();
    flush_sb();
    sreset = 1'b1;
    cycle();
    sreset = 1'b0;
    tid_log.delete();
    len_log.delete();
    hs_log.delete();
    trunc_seen   = 0;
    valid_cycles = 0;
    ready02      = 0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum;
    sreset = 1'b1; enable = 1'b1; port_mask = '1; m_tready = 1'b1;
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0;
    for (int p = 0; p < N; p++) begin mcnt[p] = 0; seq_cnt[p] = 0; popped[p] = 0; end
    repeat (2) @(posedge clk);
    #1;

    // reset state
    do_reset();
    check("reset_m_tvalid", 64'(smp_valid), 64'd0);
    check("reset_s_tready", 64'(smp_ready), 64'd0);
    check("reset_pkt_count", pkt_count[63:0], 64'd0);
    check("reset_trunc_port", 64'(trunc_port), 64'd0);

    // fairness: 3 x 4-beat packets per input, always ready
    do_reset();
    for (int r = 0; r < 3; r++) for (int p = 0; p < N; p++) add_pkt(p, 4);
    run_until_idle(200, "fair");
    check("fair_npkts", 64'(tid_log.size()), 64'd12);
    for (int i = 0; i < tid_log.size(); i++) check("fair_order", 64'(tid_log[i]), 64'(i % 4));
    for (int p = 0; p < N; p++) check("fair_count", 64'(pkt_count[p*32 +: 32]), 64'd3);
    if (hs_log.size() > 0) check("fair_span", 64'(hs_log[$] - hs_log[0] + 1), 64'd59);

    // mask: only inputs 1 and 3 may be served
    do_reset();
    port_mask = 4'b1010;
    for (int r = 0; r < 3; r++) for (int p = 0; p < N; p++) add_pkt(p, 3);
    repeat (40) cycle();
    check("mask_npkts", 64'(tid_log.size()), 64'd6);
    for (int i = 0; i < tid_log.size(); i++) check("mask_order", 64'(tid_log[i]), (i % 2 == 0) ? 64'd1 : 64'd3);
    check("mask_ready02", 64'(ready02), 64'd0);
    check("mask_count0", 64'(pkt_count[31:0]), 64'd0);
    port_mask = '1;

    // enable dropped mid-packet: packet completes, nothing more granted
    do_reset();
    add_pkt(1, 8);
    repeat (4) cycle();
    enable = 1'b0;
    add_pkt(0, 4);
    valid_cycles = 0;
    repeat (30) cycle();
    check("en_tail_valid", 64'(valid_cycles), 64'd5);
    check("en_count1", 64'(pkt_count[63:32]), 64'd1);
    check("en_count0", 64'(pkt_count[31:0]), 64'd0);
    enable = 1'b1;
    run_until_idle(50, "en");
    check("en_resume_count0", 64'(pkt_count[31:0]), 64'd1);

    // truncation of a 200-beat packet on input 2
    do_reset();
    add_pkt(2, 200);
    add_pkt(3, 3);
    run_until_idle(400, "trunc");
    check("trunc_pulses", 64'(trunc_seen), 64'd1);
    check("trunc_port_held", 64'(trunc_port), 64'd2);
    check("trunc_valid_cycles", 64'(valid_cycles), 64'd191);
    check("trunc_npkts", 64'(tid_log.size()), 64'd2);
    if (tid_log.size() == 2) begin
      check("trunc_first_id", 64'(tid_log[0]), 64'd2);
      check("trunc_first_len", 64'(len_log[0]), 64'd188);
      check("trunc_next_id", 64'(tid_log[1]), 64'd3);
    end

    // single requester: two 1-beat packets on input 3
    do_reset();
    begin
      int n0;
      n0 = cyc;
      add_pkt(3, 1);
      add_pkt(3, 1);
      run_until_idle(20, "single");
      check("single_nbeats", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
        check("single_beat1", 64'(hs_log[0]), 64'(n0 + 1));
        check("single_beat2", 64'(hs_log[1]), 64'(n0 + 3));
      end
      check("single_count3", 64'(pkt_count[127:96]), 64'd2);
    end

    // reset on beat 5 of a 10-beat packet from input 1
    do_reset();
    add_pkt(0, 2);
    add_pkt(1, 10);
    repeat (8) cycle();
    sreset = 1'b1;
    cycle();
    sreset = 1'b0;
    enable = 1'b0;
    flush_sb();
    cycle();
    check("rst_s_tready", 64'(smp_ready), 64'd0);
    check("rst_m_tvalid", 64'(smp_valid), 64'd0);
    check("rst_counts", pkt_count[63:0], 64'd0);
    flush_src();
    enable = 1'b1;
    tid_log.delete();
    add_pkt(0, 2);
    add_pkt(1, 2);
    run_until_idle(30, "rst");
    check("rst_npkts", 64'(tid_log.size()), 64'd2);
    if (tid_log.size() > 0) check("rst_first_id", 64'(tid_log[0]), 64'd0);

    // backpressure: 100 random packets, 50% ready, source gaps
    do_reset();
    gap_pct  = 10;
    rdy_rand = 1;
    for (int i = 0; i < 100; i++) add_pkt($urandom_range(0, N - 1), $urandom_range(8, 188));
    run_until_idle(70000, "bp");
    rdy_rand = 0;
    m_tready = 1'b1;
    sum = 0;
    for (int p = 0; p < N; p++) sum += int'(pkt_count[p*32 +: 32]);
    check("bp_count_sum", 64'(sum), 64'd100);
    check("bp_npkts", 64'(tid_log.size()), 64'd100);
    check("bp_no_trunc", 64'(trunc_seen), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
# axis_pkt_rr_arbiter

Packet-granular round-robin arbiter sharing one AXI-Stream datapath (typically the write side of an `axis_dist_ram_fifo`) between `NUM_INPUTS` requesters. Grants are held for a whole packet, so packets are never interleaved. The source port index is stamped on `m_tid`. A beat-count guard truncates runaway packets so one requester cannot hold the FIFO indefinitely.

## Interface
- `NUM_INPUTS`, default 4: number of requesters, from 2 to 16.
- `DATA_BYTES`, default 8: tdata width in bytes.
- `MAX_BEATS`, default 188: maximum beats per packet, equal to ceil(1500/8). Range 2 to 65535.
- `IDX_W`, derived as max(1, $clog2(NUM_INPUTS)): width of the port index.
- `clk`, in, 1: single clock.
- `sreset`, in, 1: reset. Synchronous, active-high.
- `enable`, in, 1: when low, no new grants are issued. A packet already in flight completes.
- `port_mask`, in, NUM_INPUTS: bit i=1 lets input i be granted.
- `s_tdata`, in, NUM_INPUTS*DATA_BYTES*8: input i occupies slice [i*DATA_BYTES*8 +: DATA_BYTES*8].
- `s_tkeep`, in, NUM_INPUTS*DATA_BYTES: per-input keep.
- `s_tlast`, in, NUM_INPUTS: per-input last.
- `s_tvalid`, in, NUM_INPUTS: per-input valid.
- `s_tready`, out, NUM_INPUTS: per-input ready.
- `m_tdata`, out, DATA_BYTES*8: muxed data.
- `m_tkeep`, out, DATA_BYTES: muxed keep.
- `m_tlast`, out, 1: muxed last, or forced last on truncation.
- `m_tid`, out, IDX_W: index of the granted input.
- `m_tvalid`, out, 1: output valid.
- `m_tready`, in, 1: output ready, from the FIFO.
- `trunc_pulse`, out, 1: one-cycle pulse on the forced-tlast beat.
- `trunc_port`, out, IDX_W: input index that was truncated; held until the next truncation.
- `pkt_count`, out, NUM_INPUTS*32: per-input count of packets forwarded. Each counter wraps modulo 2^32.

## Operation
- FSM with three states: IDLE, PASS, DROP. Registered state: `grant` (IDX_W), `last_grant` (IDX_W), `beat_cnt` (16 bits).
- **IDLE**
  - Candidates are inputs with `s_tvalid[i] & port_mask[i]`, considered only when `enable`=1.
  - If any candidate exists, `grant` takes the first candidate searching `last_grant+1`, `last_grant+2`, … modulo NUM_INPUTS.
  - On a grant: `last_grant` takes the granted index, `beat_cnt` is set to 0, and the FSM moves to PASS.
  - In IDLE, all `s_tready`=0 and `m_tvalid`=0.
- **PASS** (combinational mux from input `grant`)
  - `m_tvalid` = `s_tvalid[grant]`.
  - `s_tready[grant]` = `m_tready`; all other `s_tready` are 0.
  - `m_tdata`, `m_tkeep` come from the granted slice. `m_tid` = `grant`.
  - A beat is accepted when `m_tvalid & m_tready`. Each accepted beat increments `beat_cnt`.
  - Accepted beat with `s_tlast[grant]`=1: increment `pkt_count[grant]` and go to IDLE.
  - Accepted beat with `beat_cnt`=MAX_BEATS-1 and `s_tlast`=0:
    - drive `m_tlast`=1 on that beat;
    - pulse `trunc_pulse` and set `trunc_port`=`grant`;
    - increment `pkt_count[grant]`;
    - go to DROP.
  - Otherwise `m_tlast` = `s_tlast[grant]`.
- **DROP**
  - `s_tready[grant]`=1 regardless of `m_tready`, and `m_tvalid`=0, so the rest of the packet is discarded.
  - When the input presents `s_tvalid & s_tlast`, the FSM goes to IDLE.
- `port_mask` and `enable` are sampled only in IDLE. Deasserting either mid-packet has no effect on that packet.
- A masked input is never granted. Its `s_tready` stays 0, so its traffic back-pressures at the source.
- Synchronous reset has priority over every other event, including mid-packet. On reset:
  - the FSM returns to IDLE, `grant`=0, `last_grant`=NUM_INPUTS-1 (so input 0 wins first), `beat_cnt`=0;
  - `pkt_count` is all 0, `trunc_pulse`=0, `trunc_port`=0.
  - A packet that was partially forwarded is left unterminated downstream; the FIFO is reset in the same domain.

## Timing
- All outputs reset to 0. In IDLE, the mux outputs `m_tdata`, `m_tkeep`, `m_tlast`, `m_tid` are 0.
- Arbitration latency is 1 cycle. Input valid seen in IDLE on cycle N gives `m_tvalid` no earlier than cycle N+1.
- Data path latency is 0 cycles: a combinational mux with no output register.
- Exactly one idle cycle separates consecutive packets, including back-to-back packets from the same input. Maximum throughput for an L-beat packet is L/(L+1).
- `pkt_count` and `trunc_port` update on the clock edge after the final accepted beat.
- `trunc_pulse` is combinational and high only during the truncating handshake cycle.
- AXIS rule: `m_tvalid` must not drop without a handshake. This holds as long as sources obey AXIS, because the grant is stable for the whole of PASS.

## Test plan
- **Fairness.** Inputs 0–3 each hold 3 queued 4-beat packets, `m_tready`=1. Required output `m_tid` packet order: 0,1,2,3,0,1,2,3,0,1,2,3. Final `pkt_count` = 3 for every input. Each packet occupies 5 cycles, 4 beats plus 1 idle.
- **Mask and enable.** `port_mask`=4'b1010 with all inputs valid: only ids 1 and 3 alternate, and `s_tready[0]` and `s_tready[2]` never assert. With `enable`=0 raised mid-packet on input 1: that packet completes, then `m_tvalid` stays 0.
- **Backpressure.** Random `m_tready` at 50% duty, 100 packets of random length 8–188 beats across 4 inputs. Required: every packet arrives intact and unsplit, `m_tid` matches its source, and the per-input `pkt_count` values sum to 100.
- **Truncation.** Input 2 sends a 200-beat packet with MAX_BEATS=188. Required:
  - beat 188 is output with `m_tlast`=1;
  - `trunc_pulse` is high for 1 cycle and `trunc_port`=2;
  - beats 189–200 are consumed with `m_tvalid`=0;
  - the next grant goes to input 3.
- **Reset mid-packet.** Assert `sreset` on beat 5 of a 10-beat packet from input 1. Required: the next cycle all `s_tready`=0 and `m_tvalid`=0, and all counters are 0. After release, input 0 wins first when inputs 0 and 1 are both valid.
- **Single requester.** Only input 3 is valid, with 2 packets of 1 beat each. Required: output beats at cycles N+1 and N+3, `pkt_count[3]`=2.
